// File: rtl/sc1602_lcd_ctrl_pkg.sv
// sc1602_pkg: shared types and constants for the SC1602 LCD controller.
//   - state_t       : controller / nibble-sender states
//   - wait_sel_t    : selects which execution delay follows an init step
//   - init_entry_t  : one step of the power-on init ROM
//   - ceil_cycles() : converts a delay in ns to clk cycles, rounded up
//   - T_*           : delay constants in cycles at the default 90 kHz clock
//   - INIT_ROM      : HD44780 4-bit power-on sequence
//   - is_long_cmd() : true for instructions that need the long (clear/home) wait
package sc1602_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    NIB_SETUP,
    NIB_EHI,
    NIB_HOLD,
    EXEC_WAIT
  } state_t;

  typedef enum logic [1:0] {
    W_EXEC,
    W_INIT1,
    W_INIT2,
    W_CLR
  } wait_sel_t;

  typedef struct packed {
    logic      is_nibble;
    logic [7:0] data;
    wait_sel_t wait_sel;
  } init_entry_t;

  function automatic int unsigned ceil_cycles(input longint unsigned clk_hz,
                                              input longint unsigned t_ns);
    return 32'((clk_hz * t_ns + 64'd999_999_999) / 64'd1_000_000_000);
  endfunction

  localparam longint unsigned T_PWR_NS   = 40_000_000;
  localparam longint unsigned T_INIT1_NS = 4_100_000;
  localparam longint unsigned T_INIT2_NS = 100_000;
  localparam longint unsigned T_EXEC_NS  = 37_000;
  localparam longint unsigned T_CLR_NS   = 1_520_000;

  localparam int unsigned DEF_CLK_HZ = 90000;
  localparam int unsigned T_PWR   = ceil_cycles(DEF_CLK_HZ, T_PWR_NS);
  localparam int unsigned T_INIT1 = ceil_cycles(DEF_CLK_HZ, T_INIT1_NS);
  localparam int unsigned T_INIT2 = ceil_cycles(DEF_CLK_HZ, T_INIT2_NS);
  localparam int unsigned T_EXEC  = ceil_cycles(DEF_CLK_HZ, T_EXEC_NS);
  localparam int unsigned T_CLR   = ceil_cycles(DEF_CLK_HZ, T_CLR_NS);

  // The first four steps are single nibbles (the LCD still believes it is
  // in 8-bit mode); from 0x28 onward every step is a full byte.
  localparam init_entry_t INIT_ROM [8] = '{
    '{1'b1, 8'h03, W_INIT1},
    '{1'b1, 8'h03, W_INIT2},
    '{1'b1, 8'h03, W_EXEC},
    '{1'b1, 8'h02, W_EXEC},
    '{1'b0, 8'h28, W_EXEC},
    '{1'b0, 8'h0C, W_EXEC},
    '{1'b0, 8'h01, W_CLR},
    '{1'b0, 8'h06, W_EXEC}
  };

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

endpackage

// File: rtl/sc1602_lcd_ctrl_if.sv
// sc1602_lcd_ctrl_if: command byte handshake into the LCD controller.
//   cmd_valid : request carries a byte
//   cmd_ready : controller accepts a byte this cycle
//   cmd_rs    : 0 = instruction, 1 = character data
//   cmd_data  : byte to write
// master = byte producer, slave = LCD controller.
interface sc1602_lcd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sc1602_lcd_ctrl_nibble_tx.sv
// sc1602_nibble_tx: writes one 4-bit nibble to the LCD bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   abort      : synchronous cancel (PLL lock lost); drops E at the next edge
//   start      : pulse with rs/nibble to begin a nibble (accepted when idle or in HOLD)
//   rs, nibble : register select and data for the nibble
//   done       : high during the HOLD cycle, the last cycle of the nibble
//   lcd_rs, lcd_e, lcd_db : registered LCD pins
// Sequence: SETUP (1 cycle, E low) -> EHI (E_CYC cycles, E high) -> HOLD (1 cycle).
module sc1602_nibble_tx
  import sc1602_pkg::*;
#(
  parameter int unsigned E_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_db
);

  state_t     state_q, state_d;
  logic [7:0] e_cnt_q;
  logic       load;

  // A start during HOLD chains straight into the next SETUP so the two
  // nibbles of a byte go out back-to-back.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = NIB_SETUP;
          load    = 1'b1;
        end
      end
      NIB_SETUP: state_d = NIB_EHI;
      NIB_EHI: begin
        if (e_cnt_q == 8'(E_CYC - 1)) state_d = NIB_HOLD;
      end
      NIB_HOLD: begin
        if (start) begin
          state_d = NIB_SETUP;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  assign done = (state_q == NIB_HOLD);

  // E is registered from the next state so the strobe is glitch-free and
  // still drops immediately on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_cnt_q <= '0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_db  <= 4'h0;
    end else begin
      state_q <= state_d;
      e_cnt_q <= (state_q == NIB_EHI) ? e_cnt_q + 8'd1 : 8'd0;
      lcd_e   <= (state_d == NIB_EHI);
      if (abort) begin
        lcd_rs <= 1'b0;
        lcd_db <= 4'h0;
      end else if (load) begin
        lcd_rs <= rs;
        lcd_db <= nibble;
      end
    end
  end

endmodule

// File: rtl/sc1602_lcd_ctrl.sv
// sc1602_lcd_ctrl: HD44780-compatible 4-bit write-only controller for the
// SC1602 16x2 LCD. Runs the power-on init sequence after PLL lock, then
// writes command/data bytes taken over a valid/ready handshake.
//   clk, rst_n : clock (divided PLL output), asynchronous active-low reset
//   pll_lock   : start qualifier; low forces PWR_WAIT and clears init_done
//   cmd        : command byte handshake (sc1602_lcd_ctrl_if.slave)
//   init_done  : init sequence finished, sticky until reset or loss of lock
//   lcd_rs, lcd_rw, lcd_e, lcd_db : LCD pins (lcd_rw tied low)
// Optional build macro SC1602_CMD_FIFO_EN: adds a 4-entry {rs,data} FIFO in
// front of the FSM so bytes can queue up during init.
module sc1602_lcd_ctrl
  import sc1602_pkg::*;
#(
  parameter int unsigned CLK_HZ = 90000,
  parameter int unsigned E_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  sc1602_lcd_ctrl_if.slave cmd,
  output logic             init_done,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_e,
  output logic [3:0]       lcd_db
);

  localparam int unsigned PWR_CYC   = ceil_cycles(CLK_HZ, T_PWR_NS);
  localparam int unsigned INIT1_CYC = ceil_cycles(CLK_HZ, T_INIT1_NS);
  localparam int unsigned INIT2_CYC = ceil_cycles(CLK_HZ, T_INIT2_NS);
  localparam int unsigned EXEC_CYC  = ceil_cycles(CLK_HZ, T_EXEC_NS);
  localparam int unsigned CLR_CYC   = ceil_cycles(CLK_HZ, T_CLR_NS);

  function automatic logic [31:0] sel_cycles(input wait_sel_t sel);
    case (sel)
      W_INIT1: return INIT1_CYC;
      W_INIT2: return INIT2_CYC;
      W_CLR:   return CLR_CYC;
      default: return EXEC_CYC;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        low_q, low_d;
  logic        in_init_q, in_init_d;
  logic        init_done_q, init_done_d;
  init_entry_t entry;

  logic        tx_start, tx_rs, tx_done;
  logic [3:0]  tx_nib;

  logic        take, take_rs;
  logic [7:0]  take_data;

`ifdef SC1602_CMD_FIFO_EN
  logic [8:0] fifo_mem [4];
  logic [1:0] fifo_wr_q, fifo_rd_q;
  logic [2:0] fifo_cnt_q, fifo_cnt_d;
  logic       fifo_ready_q, push;

  assign push          = cmd.cmd_valid && fifo_ready_q;
  assign take          = (state_q == IDLE) && (fifo_cnt_q != 3'd0) && pll_lock;
  assign take_rs       = fifo_mem[fifo_rd_q][8];
  assign take_data     = fifo_mem[fifo_rd_q][7:0];
  assign cmd.cmd_ready = fifo_ready_q;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, take};
  end

  // Ready is registered from the next fill level, so it is low in reset and
  // while unlocked; loss of lock flushes everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_cnt_q   <= '0;
      fifo_ready_q <= 1'b0;
    end else if (!pll_lock) begin
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_cnt_q   <= '0;
      fifo_ready_q <= 1'b0;
    end else begin
      if (push) fifo_wr_q <= fifo_wr_q + 2'd1;
      if (take) fifo_rd_q <= fifo_rd_q + 2'd1;
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_ready_q <= (fifo_cnt_d != 3'd4);
    end
  end

  always_ff @(posedge clk) begin
    if (push && pll_lock) fifo_mem[fifo_wr_q] <= {cmd.cmd_rs, cmd.cmd_data};
  end
`else
  assign cmd.cmd_ready = (state_q == IDLE) && init_done_q && pll_lock;
  assign take          = cmd.cmd_valid && cmd.cmd_ready;
  assign take_rs       = cmd.cmd_rs;
  assign take_data     = cmd.cmd_data;
`endif

  // Main sequencer. NIB_SETUP stands for the whole nibble transfer here;
  // the fine SETUP/EHI/HOLD phases are tracked by the nibble sender, which
  // reports done during HOLD. EXEC_WAIT counts 0..wait inclusive, leaving
  // one guard cycle beyond the minimum execution time.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    low_d       = low_q;
    in_init_d   = in_init_q;
    init_done_d = init_done_q;
    tx_start    = 1'b0;
    tx_rs       = rs_q;
    tx_nib      = byte_q[3:0];
    entry       = INIT_ROM[idx_q];

    case (state_q)
      PWR_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == PWR_CYC - 1) begin
          state_d   = INIT;
          cnt_d     = '0;
          idx_d     = '0;
          in_init_d = 1'b1;
        end
      end
      INIT: begin
        tx_start  = 1'b1;
        tx_rs     = 1'b0;
        tx_nib    = entry.is_nibble ? entry.data[3:0] : entry.data[7:4];
        rs_d      = 1'b0;
        byte_d    = entry.data;
        low_d     = !entry.is_nibble;
        wait_d    = sel_cycles(entry.wait_sel);
        state_d   = NIB_SETUP;
      end
      IDLE: begin
        if (take) begin
          tx_start  = 1'b1;
          tx_rs     = take_rs;
          tx_nib    = take_data[7:4];
          rs_d      = take_rs;
          byte_d    = take_data;
          low_d     = 1'b1;
          in_init_d = 1'b0;
          wait_d    = is_long_cmd(take_rs, take_data) ? CLR_CYC : EXEC_CYC;
          state_d   = NIB_SETUP;
        end
      end
      NIB_SETUP: begin
        if (tx_done) begin
          if (low_q) begin
            tx_start = 1'b1;
            low_d    = 1'b0;
          end else begin
            state_d = EXEC_WAIT;
            cnt_d   = '0;
          end
        end
      end
      EXEC_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == wait_q) begin
          cnt_d = '0;
          if (in_init_q) begin
            if (idx_q == 3'd7) begin
              init_done_d = 1'b1;
              in_init_d   = 1'b0;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = INIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    // Loss of lock wins over everything and discards any byte in flight.
    if (!pll_lock) begin
      state_d     = PWR_WAIT;
      cnt_d       = '0;
      low_d       = 1'b0;
      in_init_d   = 1'b0;
      init_done_d = 1'b0;
      tx_start    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      wait_q      <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      low_q       <= 1'b0;
      in_init_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      low_q       <= low_d;
      in_init_q   <= in_init_d;
      init_done_q <= init_done_d;
    end
  end

  sc1602_nibble_tx #(.E_CYC(E_CYC)) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .abort  (!pll_lock),
    .start  (tx_start),
    .rs     (tx_rs),
    .nibble (tx_nib),
    .done   (tx_done),
    .lcd_rs (lcd_rs),
    .lcd_e  (lcd_e),
    .lcd_db (lcd_db)
  );

  assign init_done = init_done_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_sc1602_lcd_ctrl.sv
// tb_sc1602_lcd_ctrl: scoreboard bench for sc1602_lcd_ctrl at 90 kHz, E_CYC=1.
// Stimulus pushes the expected {rs,nibble} of every E pulse into a queue; a
// monitor pops and compares on each rising edge of lcd_e and logs rise/fall
// cycles for the timing checks done by the stimulus process.
module tb_sc1602_lcd_ctrl;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
  } nib_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_db;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  logic e_prev;
  nib_t exp_q[$];
  int   rise_q[$];
  int   fall_q[$];

  sc1602_lcd_ctrl_if cmd_if ();

  sc1602_lcd_ctrl #(.CLK_HZ(90000), .E_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .cmd       (cmd_if),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db    (lcd_db)
  );

  always #5 clk = ~clk;

  // cyc equals n after the n-th rising edge following reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAtLeast(input string name, input int actual, input int min_val);
    vectors++;
    if (actual < min_val) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected at least %0d", name, actual, min_val);
    end
  endtask

  // Monitor: compare each E pulse against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev <= 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_e: got rs=%0d db=0x%0h, expected no pulse", lcd_rs, lcd_db);
        end else begin
          checkOutput("nibble", {27'd0, lcd_rs, lcd_db}, {27'd0, exp_q.pop_front()});
          checkOutput("lcd_rw", {31'd0, lcd_rw}, 32'd0);
        end
      end
      if (!lcd_e && e_prev) fall_q.push_back(cyc);
      e_prev <= lcd_e;
    end
  end

  task automatic pushByte(input logic rs, input logic [7:0] data);
    exp_q.push_back({rs, data[7:4]});
    exp_q.push_back({rs, data[3:0]});
  endtask

  task automatic pushInit();
    logic [3:0] seq [12];
    seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, seq[i]});
  endtask

  // Offer a byte and wait for the handshake; returns at the negedge right
  // after the accepting clock edge with acc_cyc = that edge's number.
  task automatic applyStimulus(input logic rs, input logic [7:0] data,
                               input bit keep_valid, output int acc_cyc);
    int n = 0;
    pushByte(rs, data);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rs    = rs;
    cmd_if.cmd_data  = data;
    while (!cmd_if.cmd_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) checkOutput("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic waitInitDone(input int bound);
    int n = 0;
    while (!init_done && n < bound) begin
      n++;
      @(negedge clk);
    end
    checkOutput("init_done_reached", {31'd0, init_done}, 32'd1);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      n++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, n, base, relock;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rs    = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    pll_lock         = 1'b1;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    checkOutput("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    checkOutput("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    checkOutput("rst_lcd_db", {28'd0, lcd_db}, 32'd0);

    rst_n = 1'b1;
    pushInit();

`ifdef SC1602_CMD_FIFO_EN
    applyStimulus(1'b1, 8'h48, 1'b0, acc);
    applyStimulus(1'b1, 8'h69, 1'b0, acc);
    applyStimulus(1'b0, 8'hC0, 1'b0, acc);
    applyStimulus(1'b1, 8'h21, 1'b0, acc);
    checkOutput("fifo_full_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = 8'h55;
    repeat (3) @(negedge clk);
    checkOutput("fifo_full_hold", {31'd0, cmd_if.cmd_ready}, 32'd0);
    cmd_if.cmd_valid = 1'b0;
`endif

    while (cyc < 3000) @(negedge clk);
    checkOutput("pwr_wait_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("pwr_wait_lcd_e", {31'd0, lcd_e}, 32'd0);

    waitInitDone(20000);
    checkOutput("init_pulse_count", 32'(rise_q.size()), 32'd12);
    if (rise_q.size() >= 12 && fall_q.size() >= 10) begin
      checkOutput("first_e_rise", 32'(rise_q[0]), 32'd3602);
      checkAtLeast("gap_after_first", rise_q[1] - fall_q[0], 369);
      checkOutput("byte_nibble_spacing", 32'(rise_q[5] - rise_q[4]), 32'd3);
      checkAtLeast("gap_after_clear", rise_q[10] - fall_q[9], 137);
    end

`ifdef SC1602_CMD_FIFO_EN
    exp_q.push_back({1'b1, 4'h4}); exp_q.push_back({1'b1, 4'h8});
    exp_q.push_back({1'b1, 4'h6}); exp_q.push_back({1'b1, 4'h9});
    exp_q.push_back({1'b0, 4'hC}); exp_q.push_back({1'b0, 4'h0});
    exp_q.push_back({1'b1, 4'h2}); exp_q.push_back({1'b1, 4'h1});
    waitDrain(2000);
`else
    checkOutput("ready_after_init", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Character write: ready stays low 2*(1+2)+4+1 cycles.
    applyStimulus(1'b1, 8'h41, 1'b0, acc);
    n = 0;
    while (!cmd_if.cmd_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("ready_low_0x41", 32'(n), 32'd11);

    // Clear display followed by a held-valid DDRAM address.
    base = rise_q.size();
    applyStimulus(1'b0, 8'h01, 1'b1, acc);
    applyStimulus(1'b0, 8'h80, 1'b0, acc);
    waitDrain(1000);
    if (rise_q.size() >= base + 4 && fall_q.size() >= base + 2)
      checkAtLeast("gap_after_user_clear", rise_q[base + 2] - fall_q[base + 1], 137);

    // Lose lock during EXEC_WAIT, then re-lock and repeat init.
    applyStimulus(1'b0, 8'h06, 1'b0, acc);
    repeat (7) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    checkOutput("unlock_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("unlock_lcd_e", {31'd0, lcd_e}, 32'd0);
    checkOutput("unlock_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("unlocked_e_quiet", {31'd0, lcd_e}, 32'd0);
    pushInit();
    base   = rise_q.size();
    pll_lock = 1'b1;
    relock = cyc;
    waitInitDone(20000);
    if (rise_q.size() > base)
      checkOutput("relock_first_rise", 32'(rise_q[base]), 32'(relock + 3602));
    else
      checkOutput("relock_first_rise", 32'd0, 32'(relock + 3602));
    waitDrain(100);

    // Asynchronous reset in the middle of an E pulse.
    applyStimulus(1'b1, 8'h55, 1'b0, acc);
    @(posedge clk);
    #2;
    checkOutput("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    checkOutput("async_rst_lcd_db", {28'd0, lcd_db}, 32'd0);
    checkOutput("async_rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    exp_q.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
